// File: rtl/word_cache.sv
`default_nettype none
// ============================================================================
// Module   : word_cache
// Purpose  : Direct-mapped, read-only word cache. A hit is answered on the
//            next cycle, so back-to-back hits return one word per cycle. A
//            miss requests the whole line from backing memory, writes it into
//            the selected line, and returns the requested word on the cycle
//            after fill_ack.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            rd_valid/rd_ready  - read request handshake, rd_addr word address
//            rd_data/_valid/hit - registered response, rd_hit=0 when filled
//            fill_req/fill_addr - line fill request to memory, {tag,index}
//            fill_ack/fill_data - fill completion and line contents
//            inv                - invalidate all lines (ignored while filling)
//            hit_cnt/miss_cnt   - saturating hit and miss counters
// Revision : 1.0 - initial release
// ============================================================================
module word_cache #(
  parameter int WORD_W     = 3,
  parameter int LINE_WORDS = 8,
  parameter int LINES      = 4,
  parameter int MEM_ADDR_W = 6,
  parameter int LINE_W     = WORD_W * LINE_WORDS,
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int IDX_W      = $clog2(LINES),
  parameter int TAG_W      = MEM_ADDR_W - OFF_W - IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [MEM_ADDR_W-1:0]       rd_addr,
  output logic [WORD_W-1:0]           rd_data,
  output logic                        rd_data_valid,
  output logic                        rd_hit,
  output logic                        fill_req,
  output logic [MEM_ADDR_W-OFF_W-1:0] fill_addr,
  input  logic                        fill_ack,
  input  logic [LINE_W-1:0]           fill_data,
  input  logic                        inv,
  output logic [15:0]                 hit_cnt,
  output logic [15:0]                 miss_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]        r_state;

  // Line storage. Only the valid bits are reset; tag/data are never
  // consulted while their valid bit is clear.
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  // Request fields captured at the accepted miss.
  logic [OFF_W-1:0]  r_miss_off;
  logic [IDX_W-1:0]  r_miss_idx;
  logic [TAG_W-1:0]  r_miss_tag;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_accept;
  logic              w_hit;
  logic              w_fill_done;
  logic [LINE_W-1:0] w_line;
  logic [WORD_W-1:0] w_hit_words  [LINE_WORDS];
  logic [WORD_W-1:0] w_fill_words [LINE_WORDS];

  assign w_off = rd_addr[OFF_W-1:0];
  assign w_idx = rd_addr[OFF_W +: IDX_W];
  assign w_tag = rd_addr[MEM_ADDR_W-1 -: TAG_W];

  // inv takes priority over a pending request.
  assign rd_ready    = (r_state == IDLE) && !inv;
  assign w_accept    = rd_valid && rd_ready;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_done = (r_state == FILL) && fill_ack;
  assign w_line      = r_data[w_idx];

  // Split the resident line and the incoming fill line into words.
  generate
    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_word
      assign w_hit_words[k]  = w_line[k*WORD_W +: WORD_W];
      assign w_fill_words[k] = fill_data[k*WORD_W +: WORD_W];
    end
  endgenerate

  // Control, valid bits, response and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_valid       <= '0;
      rd_data_valid <= 1'b0;
      rd_hit        <= 1'b0;
      rd_data       <= '0;
      fill_req      <= 1'b0;
      fill_addr     <= '0;
      hit_cnt       <= 16'd0;
      miss_cnt      <= 16'd0;
    end else begin
      rd_data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (inv) begin
            r_valid <= '0;
          end else if (w_accept) begin
            if (w_hit) begin
              rd_data_valid <= 1'b1;
              rd_hit        <= 1'b1;
              rd_data       <= w_hit_words[w_off];
              if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
              r_state   <= FILL;
              fill_req  <= 1'b1;
              fill_addr <= {w_tag, w_idx};
              if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        FILL: begin
          if (fill_ack) begin
            r_state             <= IDLE;
            fill_req            <= 1'b0;
            r_valid[r_miss_idx] <= 1'b1;
            rd_data_valid       <= 1'b1;
            rd_hit              <= 1'b0;
            // Answer straight from the incoming line, not the array.
            rd_data             <= w_fill_words[r_miss_off];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data storage and miss fields; no reset needed. The !rst gate keeps
  // a fill abandoned by reset from touching the array.
  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) begin
      r_tag[r_miss_idx]  <= r_miss_tag;
      r_data[r_miss_idx] <= fill_data;
    end
    if (w_accept && !w_hit) begin
      r_miss_off <= w_off;
      r_miss_idx <= w_idx;
      r_miss_tag <= w_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_cache
// Purpose  : Directed self-checking bench for word_cache (default parameters).
//            Address layout: [5]=tag, [4:3]=index, [2:0]=offset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid;
  logic        rd_ready;
  logic [5:0]  rd_addr;
  logic [2:0]  rd_data;
  logic        rd_data_valid;
  logic        rd_hit;
  logic        fill_req;
  logic [2:0]  fill_addr;
  logic        fill_ack;
  logic [23:0] fill_data;
  logic        inv;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  word_cache dut (
    .clk           (clk),
    .rst           (rst),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_hit        (rd_hit),
    .fill_req      (fill_req),
    .fill_addr     (fill_addr),
    .fill_ack      (fill_ack),
    .fill_data     (fill_data),
    .inv           (inv),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs changed 1 ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rd_valid = 1'b0; rd_addr = '0; fill_ack = 1'b0;
    fill_data = '0; inv = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state, rd_ready high right away.
    chk("rst_ready",    {31'd0, rd_ready},      32'd1);
    chk("rst_dvalid",   {31'd0, rd_data_valid}, 32'd0);
    chk("rst_hit",      {31'd0, rd_hit},        32'd0);
    chk("rst_fill_req", {31'd0, fill_req},      32'd0);
    chk("rst_data",     {29'd0, rd_data},       32'd0);
    chk("rst_faddr",    {29'd0, fill_addr},     32'd0);
    chk("rst_hitcnt",   {16'd0, hit_cnt},       32'd0);
    chk("rst_misscnt",  {16'd0, miss_cnt},      32'd0);

    // Miss on 6'h05 -> fill of line address 0.
    rd_valid = 1'b1; rd_addr = 6'h05;
    tick();
    rd_valid = 1'b0;
    chk("m1_fill_req", {31'd0, fill_req},  32'd1);
    chk("m1_faddr",    {29'd0, fill_addr}, 32'd0);
    chk("m1_ready",    {31'd0, rd_ready},  32'd0);
    chk("m1_misscnt",  {16'd0, miss_cnt},  32'd1);
    tick();  // fill request must stay up without an ack
    chk("m1_req_hold", {31'd0, fill_req},  32'd1);
    chk("m1_no_resp",  {31'd0, rd_data_valid}, 32'd0);
    fill_ack = 1'b1; fill_data = 24'o76543210;
    tick();
    fill_ack = 1'b0;
    chk("m1_dvalid",   {31'd0, rd_data_valid}, 32'd1);
    chk("m1_data",     {29'd0, rd_data},       32'd5);
    chk("m1_hit",      {31'd0, rd_hit},        32'd0);
    chk("m1_req_off",  {31'd0, fill_req},      32'd0);
    chk("m1_ready2",   {31'd0, rd_ready},      32'd1);
    tick();
    chk("m1_pulse",    {31'd0, rd_data_valid}, 32'd0);
    chk("m1_hold",     {29'd0, rd_data},       32'd5);

    // Stray fill_ack in IDLE must not alter the line.
    fill_ack = 1'b1; fill_data = 24'o11111111;
    tick();
    fill_ack = 1'b0;
    chk("stray_ack",   {31'd0, rd_data_valid}, 32'd0);

    // Back-to-back hits 6'h02, 6'h07.
    rd_valid = 1'b1; rd_addr = 6'h02;
    tick();
    rd_addr = 6'h07;
    chk("h1_dvalid", {31'd0, rd_data_valid}, 32'd1);
    chk("h1_data",   {29'd0, rd_data},       32'd2);
    chk("h1_hit",    {31'd0, rd_hit},        32'd1);
    chk("h1_ready",  {31'd0, rd_ready},      32'd1);
    tick();
    rd_valid = 1'b0;
    chk("h2_dvalid", {31'd0, rd_data_valid}, 32'd1);
    chk("h2_data",   {29'd0, rd_data},       32'd7);
    chk("h2_hit",    {31'd0, rd_hit},        32'd1);
    chk("h2_hitcnt", {16'd0, hit_cnt},       32'd2);

    // Conflicting miss 6'h22 (tag 1, index 0) evicts line 0.
    rd_valid = 1'b1; rd_addr = 6'h22;
    tick();
    rd_valid = 1'b0;
    chk("m2_fill_req", {31'd0, fill_req},  32'd1);
    chk("m2_faddr",    {29'd0, fill_addr}, 32'd4);
    fill_ack = 1'b1; fill_data = 24'o01234567;
    tick();
    fill_ack = 1'b0;
    chk("m2_dvalid", {31'd0, rd_data_valid}, 32'd1);
    chk("m2_data",   {29'd0, rd_data},       32'd5);
    chk("m2_hit",    {31'd0, rd_hit},        32'd0);
    chk("m2_misscnt",{16'd0, miss_cnt},      32'd2);

    // 6'h05 now misses.
    rd_valid = 1'b1; rd_addr = 6'h05;
    tick();
    rd_valid = 1'b0;
    chk("m3_fill_req", {31'd0, fill_req},      32'd1);
    chk("m3_faddr",    {29'd0, fill_addr},     32'd0);
    chk("m3_no_resp",  {31'd0, rd_data_valid}, 32'd0);
    fill_ack = 1'b1; fill_data = 24'o76543210;
    tick();
    fill_ack = 1'b0;
    chk("m3_data",     {29'd0, rd_data},   32'd5);
    chk("m3_misscnt",  {16'd0, miss_cnt},  32'd3);

    // Hit on 6'h03 confirms the line is resident before invalidation.
    rd_valid = 1'b1; rd_addr = 6'h03;
    tick();
    rd_valid = 1'b0;
    chk("h3_hit",  {31'd0, rd_hit},  32'd1);
    chk("h3_data", {29'd0, rd_data}, 32'd3);

    // inv with rd_valid: request blocked, all lines invalidated.
    rd_valid = 1'b1; rd_addr = 6'h03; inv = 1'b1;
    #1;
    chk("inv_ready", {31'd0, rd_ready}, 32'd0);
    tick();
    inv = 1'b0; rd_valid = 1'b0;
    chk("inv_no_resp", {31'd0, rd_data_valid}, 32'd0);
    chk("inv_no_fill", {31'd0, fill_req},      32'd0);
    rd_valid = 1'b1; rd_addr = 6'h03;
    tick();
    rd_valid = 1'b0;
    chk("inv_miss",    {31'd0, fill_req},      32'd1);
    chk("inv_misscnt", {16'd0, miss_cnt},      32'd4);
    fill_ack = 1'b1; fill_data = 24'o76543210;
    tick();
    fill_ack = 1'b0;
    chk("inv_fill_data", {29'd0, rd_data}, 32'd3);

    // Reset in the middle of a fill on 6'h10 (index 2).
    rd_valid = 1'b1; rd_addr = 6'h10;
    tick();
    rd_valid = 1'b0;
    chk("rf_fill_req", {31'd0, fill_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_req_off", {31'd0, fill_req},  32'd0);
    chk("rf_ready",   {31'd0, rd_ready},  32'd1);
    chk("rf_misscnt", {16'd0, miss_cnt},  32'd0);
    fill_ack = 1'b1; fill_data = 24'o76543210;
    tick();
    fill_ack = 1'b0;
    chk("rf_no_resp1", {31'd0, rd_data_valid}, 32'd0);
    tick();
    chk("rf_no_resp2", {31'd0, rd_data_valid}, 32'd0);
    chk("rf_req_off2", {31'd0, fill_req},      32'd0);
    rd_valid = 1'b1; rd_addr = 6'h10;
    tick();
    rd_valid = 1'b0;
    chk("rf_miss",    {31'd0, fill_req},      32'd1);
    chk("rf_faddr",   {29'd0, fill_addr},     32'd2);
    chk("rf_no_hit",  {31'd0, rd_data_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
